// File: rtl/iob_eth_rx_pkg.sv
// Shared constants, state encoding and CRC-32 helper for the MII receive engine.
package iob_eth_rx_pkg;

  localparam logic [7:0]  IOB_ETH_SFD             = 8'hD5;
  localparam logic [3:0]  IOB_ETH_PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  IOB_ETH_SFD_HI_NIBBLE   = IOB_ETH_SFD[7:4];
  localparam int          IOB_ETH_MIN_FCS_BYTES   = 4;

  // Reflected Ethernet CRC-32; register is never complemented, so a good
  // frame followed by its FCS leaves the fixed residue below.
  localparam logic [31:0] IOB_ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] IOB_ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] IOB_ETH_CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_LO,
    ST_HI,
    ST_CHECK,
    ST_DONE
  } rx_state_t;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ IOB_ETH_CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/iob_eth_crc.sv
// Byte-wide Ethernet CRC-32 register; restarts while start_i is high.
module iob_eth_crc
  import iob_eth_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        start_i,
  input  logic        data_en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)         crc_o <= IOB_ETH_CRC_INIT;
    else if (start_i)   crc_o <= IOB_ETH_CRC_INIT;
    else if (data_en_i) crc_o <= crc32_byte(crc_o, data_i);
  end

endmodule

// File: rtl/iob_eth_rx.sv
// MII receive engine: strips preamble/SFD, writes frame bytes to the RX buffer,
// checks the FCS and presents length/status until acknowledged.
module iob_eth_rx
  import iob_eth_rx_pkg::*;
#(
  parameter int BUF_ADDR_W = 11
) (
  input  logic                  arst_i,
  input  logic                  rx_clk_i,
  input  logic                  rx_dv_i,
  input  logic                  rx_er_i,
  input  logic [3:0]            rx_data_i,
  output logic [BUF_ADDR_W-1:0] addr_o,
  output logic [7:0]            data_o,
  output logic                  wr_o,
  output logic                  data_ready_o,
  output logic [BUF_ADDR_W-1:0] nbytes_o,
  output logic                  crc_err_o,
  output logic                  rx_err_o,
  input  logic                  rcv_ack_i
);

  localparam logic [BUF_ADDR_W:0] MIN_BYTES = (BUF_ADDR_W+1)'(IOB_ETH_MIN_FCS_BYTES);

  rx_state_t             state;
  logic [BUF_ADDR_W:0]   cnt;     // msb set means the buffer is full
  logic [3:0]            lo_nib;
  logic [31:0]           crc;

  iob_eth_crc u_crc (
    .clk_i     (rx_clk_i),
    .arst_i    (arst_i),
    .start_i   (state == ST_IDLE),
    .data_en_i (wr_o),
    .data_i    (data_o),
    .crc_o     (crc)
  );

  always_ff @(posedge rx_clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      lo_nib       <= '0;
      addr_o       <= '0;
      data_o       <= '0;
      wr_o         <= 1'b0;
      data_ready_o <= 1'b0;
      nbytes_o     <= '0;
      crc_err_o    <= 1'b0;
      rx_err_o     <= 1'b0;
    end else begin
      // NOTE: non-blocking default makes wr_o a single-cycle strobe; later
      // assignments in the same cycle override it without creating a latch.
      wr_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          addr_o    <= '0;
          cnt       <= '0;
          crc_err_o <= 1'b0;
          rx_err_o  <= 1'b0;
          if (rx_dv_i && !data_ready_o && rx_data_i == IOB_ETH_PREAMBLE_NIBBLE)
            state <= ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (!rx_dv_i)                                  state <= ST_IDLE;
          else if (rx_data_i == IOB_ETH_SFD_HI_NIBBLE)   state <= ST_LO;
          else if (rx_data_i != IOB_ETH_PREAMBLE_NIBBLE) state <= ST_IDLE;
        end
        ST_LO: begin
          if (rx_er_i) rx_err_o <= 1'b1;
          if (rx_dv_i) begin
            lo_nib <= rx_data_i;
            state  <= ST_HI;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_HI: begin
          if (rx_er_i) rx_err_o <= 1'b1;
          if (rx_dv_i) begin
            state <= ST_LO;
            if (cnt[BUF_ADDR_W]) begin
              rx_err_o <= 1'b1;
            end else begin
              wr_o   <= 1'b1;
              data_o <= {rx_data_i, lo_nib};
              addr_o <= cnt[BUF_ADDR_W-1:0];
              cnt    <= cnt + 1'b1;
            end
          end else begin
            // odd nibble count: the pending low nibble is dropped
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          crc_err_o    <= (crc != IOB_ETH_CRC_RESIDUE) || (cnt < MIN_BYTES);
          nbytes_o     <= cnt[BUF_ADDR_W] ? '1 : cnt[BUF_ADDR_W-1:0];
          data_ready_o <= 1'b1;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          if (rcv_ack_i) begin
            data_ready_o <= 1'b0;
            nbytes_o     <= '0;
            crc_err_o    <= 1'b0;
            rx_err_o     <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_rx.sv
// Directed bench for iob_eth_rx with a write scoreboard fed by the stimulus.
module tb_iob_eth_rx;

  localparam int AW = 11;

  logic          rx_clk = 1'b0;
  logic          arst   = 1'b1;
  logic          rx_dv  = 1'b0;
  logic          rx_er  = 1'b0;
  logic [3:0]    rx_data = 4'h0;
  logic          rcv_ack = 1'b0;
  logic [AW-1:0] addr_o;
  logic [7:0]    data_o;
  logic          wr_o;
  logic          data_ready_o;
  logic [AW-1:0] nbytes_o;
  logic          crc_err_o;
  logic          rx_err_o;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [AW+7:0] exp_q[$];
  logic [7:0]    frame[$];

  iob_eth_rx #(.BUF_ADDR_W(AW)) dut (
    .arst_i       (arst),
    .rx_clk_i     (rx_clk),
    .rx_dv_i      (rx_dv),
    .rx_er_i      (rx_er),
    .rx_data_i    (rx_data),
    .addr_o       (addr_o),
    .data_o       (data_o),
    .wr_o         (wr_o),
    .data_ready_o (data_ready_o),
    .nbytes_o     (nbytes_o),
    .crc_err_o    (crc_err_o),
    .rx_err_o     (rx_err_o),
    .rcv_ack_i    (rcv_ack)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every observed write must match the head of the expected queue.
  always @(negedge rx_clk) begin
    if (!arst && wr_o) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_wr", {13'd0, addr_o, data_o}, 32'hFFFFFFFF);
      end else begin
        check("wr_addr_data", {13'd0, addr_o, data_o}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive(input logic dv, input logic [3:0] d, input logic er);
    @(negedge rx_clk);
    rx_dv   = dv;
    rx_data = d;
    rx_er   = er;
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
  endtask

  // Sends the global frame; rx_er pulses on the high nibble of byte er_byte.
  task automatic send_frame(input int er_byte, input bit odd_nib);
    send_preamble();
    for (int i = 0; i < frame.size(); i++) begin
      drive(1'b1, frame[i][3:0], 1'b0);
      drive(1'b1, frame[i][7:4], i == er_byte);
    end
    if (odd_nib) drive(1'b1, 4'h7, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic push_expected();
    for (int i = 0; i < frame.size() && i < (1 << AW); i++)
      exp_q.push_back({AW'(i), frame[i]});
  endtask

  task automatic load_good(input logic [7:0] last_fcs);
    logic [7:0] good[13];
    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'h26, 8'h39, 8'hF4, 8'hCB};
    frame.delete();
    foreach (good[i]) frame.push_back(good[i]);
    frame[12] = last_fcs;
  endtask

  task automatic wait_ready(input string tag, input int limit);
    for (int i = 0; i < limit && !data_ready_o; i++) @(negedge rx_clk);
    check(tag, {31'd0, data_ready_o}, 32'd1);
  endtask

  task automatic ack();
    @(negedge rx_clk);
    rcv_ack = 1'b1;
    @(negedge rx_clk);
    rcv_ack = 1'b0;
    check("ack_drops_ready", {31'd0, data_ready_o}, 32'd0);
  endtask

  task automatic check_status(input string tag, input int nb, input logic ce, input logic re);
    check({tag, "_nbytes"}, {21'd0, nbytes_o}, nb);
    check({tag, "_crc_err"}, {31'd0, crc_err_o}, {31'd0, ce});
    check({tag, "_rx_err"}, {31'd0, rx_err_o}, {31'd0, re});
    check({tag, "_all_written"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int wr_base;

    // Reset state
    repeat (3) @(negedge rx_clk);
    check("reset_wr", {31'd0, wr_o}, 32'd0);
    check("reset_ready", {31'd0, data_ready_o}, 32'd0);
    check("reset_addr", {21'd0, addr_o}, 32'd0);
    check("reset_nbytes", {21'd0, nbytes_o}, 32'd0);
    check("reset_flags", {30'd0, crc_err_o, rx_err_o}, 32'd0);
    arst = 1'b0;
    repeat (2) @(negedge rx_clk);

    // Good frame with exact status latency
    load_good(8'hCB);
    push_expected();
    send_frame(-1, 1'b0);
    @(negedge rx_clk);
    check("good_ready_lat1", {31'd0, data_ready_o}, 32'd0);
    @(negedge rx_clk);
    check("good_ready_lat2", {31'd0, data_ready_o}, 32'd1);
    check_status("good", 13, 1'b0, 1'b0);

    // Frame arriving while status is held is ignored entirely
    load_good(8'h00);
    send_frame(-1, 1'b0);
    repeat (4) @(negedge rx_clk);
    check("hold_ready", {31'd0, data_ready_o}, 32'd1);
    check_status("hold", 13, 1'b0, 1'b0);
    ack();
    check("ack_nbytes_clear", {21'd0, nbytes_o}, 32'd0);

    // Bad FCS, received from address 0 after the ack
    load_good(8'hCA);
    push_expected();
    send_frame(-1, 1'b0);
    wait_ready("badfcs_ready", 10);
    check_status("badfcs", 13, 1'b1, 1'b0);
    ack();

    // Aborted preamble and bad SFD nibble
    repeat (2) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hC, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 4'(i + 1), 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    repeat (6) @(negedge rx_clk);
    check("abort_no_ready", {31'd0, data_ready_o}, 32'd0);
    check("abort_no_writes", exp_q.size(), 32'd0);

    // rx_er mid-payload: all bytes still written, sticky error
    load_good(8'hCB);
    push_expected();
    send_frame(5, 1'b0);
    wait_ready("rxer_ready", 10);
    check_status("rxer", 13, 1'b0, 1'b1);
    ack();

    // Runt frame
    frame.delete();
    frame.push_back(8'hAA);
    frame.push_back(8'hBB);
    push_expected();
    send_frame(-1, 1'b0);
    wait_ready("runt_ready", 10);
    check_status("runt", 2, 1'b1, 1'b0);
    ack();

    // Odd trailing nibble is dropped
    load_good(8'hCB);
    push_expected();
    send_frame(-1, 1'b1);
    wait_ready("odd_ready", 10);
    check_status("odd", 13, 1'b0, 1'b0);
    ack();

    // Reset mid-payload abandons the frame
    load_good(8'hCB);
    send_preamble();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({AW'(i), frame[i]});
      drive(1'b1, frame[i][3:0], 1'b0);
      drive(1'b1, frame[i][7:4], 1'b0);
    end
    drive(1'b1, frame[3][3:0], 1'b0);
    @(negedge rx_clk);
    arst = 1'b1;
    rx_dv = 1'b0;
    #1;
    check("midrst_wr", {31'd0, wr_o}, 32'd0);
    check("midrst_addr", {21'd0, addr_o}, 32'd0);
    check("midrst_data", {24'd0, data_o}, 32'd0);
    @(negedge rx_clk);
    arst = 1'b0;
    repeat (6) @(negedge rx_clk);
    check("midrst_no_ready", {31'd0, data_ready_o}, 32'd0);
    check("midrst_partial_writes", exp_q.size(), 32'd0);

    // Overflow: 2100 bytes into a 2048-byte buffer
    frame.delete();
    for (int i = 0; i < 2100; i++) frame.push_back(8'(i * 7 + 3));
    push_expected();
    wr_base = wr_count;
    send_frame(-1, 1'b0);
    wait_ready("ovf_ready", 10);
    check("ovf_write_count", wr_count - wr_base, 32'd2048);
    check_status("ovf", 2047, crc_err_o, 1'b1);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
